instruction_fetch: RTL and testbench

//   IF stage of the MIPS pipeline, directly upstream of Instruction_Mem.

---
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, addresses instruction
// memory by word, and registers the returned instruction into IF/ID.
// Redirects (branch, then jump) take priority over stall; stall holds state.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  // The pc is always word aligned, so the low two bits are forced to zero
  // at every load, including the reset value.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target_aligned;

  // Next sequential address (wraps at 2^32) and the two redirect targets.
  // The jump target uses the PC+4 of the jump instruction sitting in IF/ID.
  always_comb begin
    w_pc_plus4              = r_pc + 32'd4;
    w_jump_target           = {r_ifid_pc_plus4[31:28], jump_index, 2'b00};
    w_branch_target_aligned = branch_target & ~32'd3;
  end

  // PC and IF/ID update: branch > jump > stall > sequential fetch.
  // A redirect flushes IF/ID to a bubble but keeps ifid_pc_plus4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC_ALIGNED;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= 32'd0;
      r_ifid_valid    <= 1'b0;
      r_fetch_count   <= 32'd0;
    end else if (branch_taken) begin
      r_pc         <= w_branch_target_aligned;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (jump) begin
      r_pc         <= w_jump_target;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_pc            <= w_pc_plus4;
      r_ifid_instr    <= imem_instr;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= 1'b1;
      r_fetch_count   <= r_fetch_count + 32'd1;
    end
  end

  // Outputs: word address is a pure function of the pc.
  always_comb begin
    imem_addr     = {2'b00, r_pc[31:2]};
    pc            = r_pc;
    ifid_instr    = r_ifid_instr;
    ifid_pc_plus4 = r_ifid_pc_plus4;
    ifid_valid    = r_ifid_valid;
    fetch_count   = r_fetch_count;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of per-cycle controls with
// hand-computed expected outputs, plus hand-written reset sequences.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int total;
  int bad;

  localparam logic [31:0] NOP = 32'h0000_0000;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word k holds a recognisable non-NOP pattern.
  function automatic logic [31:0] mw(input int unsigned k);
    logic [31:0] kk;
    kk = k;
    return 32'hA500_0000 | {24'd0, kk[7:0]};
  endfunction

  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mw(i);
  end
  assign imem_instr = mem[imem_addr[7:0]];

  // Comparison helper.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " imem_addr"}, imem_addr, e_pc >> 2);
    check({tag, " ifid_instr"}, ifid_instr, e_instr);
    check({tag, " ifid_pc_plus4"}, ifid_pc_plus4, e_pc4);
    check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    check({tag, " fetch_count"}, fetch_count, e_cnt);
  endtask

  // One vector: controls applied before an edge, outputs expected after it.
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic j,
                     input logic [25:0] ji, input logic [31:0] epc, input logic [31:0] ein,
                     input logic [31:0] ep4, input logic ev, input logic [31:0] ec);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.jmp = j; v.jidx = ji;
    v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4; v.e_valid = ev; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_index = 26'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b1;

    //      st br target         jp jidx      pc             instr      pc4            v  cnt
    add(0, 0, 32'h0,          0, 26'h0,  32'h4,         mw(0),     32'h4,         1, 1);   // sequential
    add(0, 0, 32'h0,          0, 26'h0,  32'h8,         mw(1),     32'h8,         1, 2);
    add(1, 0, 32'h0,          0, 26'h0,  32'h8,         mw(1),     32'h8,         1, 2);   // stall x3
    add(1, 0, 32'h0,          0, 26'h0,  32'h8,         mw(1),     32'h8,         1, 2);
    add(1, 0, 32'h0,          0, 26'h0,  32'h8,         mw(1),     32'h8,         1, 2);
    add(0, 0, 32'h0,          0, 26'h0,  32'hC,         mw(2),     32'hC,         1, 3);   // resume
    add(0, 0, 32'h0,          0, 26'h0,  32'h10,        mw(3),     32'h10,        1, 4);
    add(0, 1, 32'h43,         0, 26'h0,  32'h40,        NOP,       32'h10,        0, 4);   // branch, low bits masked
    add(0, 0, 32'h0,          0, 26'h0,  32'h44,        mw(16),    32'h44,        1, 5);
    add(0, 0, 32'h0,          0, 26'h0,  32'h48,        mw(17),    32'h48,        1, 6);
    add(0, 0, 32'h0,          1, 26'h30, 32'hC0,        NOP,       32'h48,        0, 6);   // jump
    add(0, 0, 32'h0,          0, 26'h0,  32'hC4,        mw(48),    32'hC4,        1, 7);
    add(1, 1, 32'h80,         0, 26'h0,  32'h80,        NOP,       32'hC4,        0, 7);   // stall+branch
    add(0, 1, 32'h20,         1, 26'h3,  32'h20,        NOP,       32'hC4,        0, 7);   // branch beats jump
    add(1, 0, 32'h0,          1, 26'h5,  32'h14,        NOP,       32'hC4,        0, 7);   // stall+jump
    add(0, 0, 32'h0,          0, 26'h0,  32'h18,        mw(5),     32'h18,        1, 8);
    add(0, 1, 32'hFFFF_FFFC,  0, 26'h0,  32'hFFFF_FFFC, NOP,       32'h18,        0, 8);
    add(0, 0, 32'h0,          0, 26'h0,  32'h0,         mw(255),   32'h0,         1, 9);   // pc wraps
    add(0, 0, 32'h0,          0, 26'h0,  32'h4,         mw(0),     32'h4,         1, 10);
    add(0, 1, 32'h1000_0004,  0, 26'h0,  32'h1000_0004, NOP,       32'h4,         0, 10);
    add(0, 0, 32'h0,          0, 26'h0,  32'h1000_0008, mw(1),     32'h1000_0008, 1, 11);
    add(0, 0, 32'h0,          1, 26'h10, 32'h1000_0040, NOP,       32'h1000_0008, 0, 11);  // jump keeps upper nibble
    add(0, 0, 32'h0,          0, 26'h0,  32'h1000_0044, mw(16),    32'h1000_0044, 1, 12);

    // Reset asserted mid-cycle, no edge needed; holds with clock running.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("reset_async", 32'h0, NOP, 32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 32'h0, NOP, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < vq.size(); i++) begin
      stall         = vq[i].stall;
      branch_taken  = vq[i].br;
      branch_target = vq[i].tgt;
      jump          = vq[i].jmp;
      jump_index    = vq[i].jidx;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_instr, vq[i].e_pc4,
                vq[i].e_valid, vq[i].e_cnt);
      @(negedge clk);
    end
    idle_inputs();

    // Reset pulse mid-run: everything returns to reset values at once.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("reset_midrun", 32'h0, NOP, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_reset_fetch", 32'h4, mw(0), 32'h4, 1'b1, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 expected earlier");
    $fatal(1, "timeout");
  end

endmodule
